byte_fifo: RTL and testbench
============================

// Module: byte_fifo
// PURPOSE
//   Valid/ready FIFO that buffers bytes ahead of the 8-bit register stage.
//   Absorbs bursts from the upstream producer and feeds the register's d
//   input. Also provides a one-cycle load strobe (out_valid & out_ready).
//   First-word fall-through: the head entry is visible on out_data whenever
//   out_valid is high.
// PARAMETERS
//   WIDTH      8   data width in bits
//   DEPTH      4   number of entries; power of two, >= 2
//   AFULL_LVL  3   almost_full asserts when count >= AFULL_LVL (1..DEPTH)
// PORTS
//   clk          in   1                    clock, all state on posedge
//   rst          in   1                    async reset, active-high
//   flush        in   1                    sync clear of all entries
//   in_data      in   WIDTH                write data
//   in_valid     in   1                    write request
//   in_ready     out  1                    FIFO can accept (not full)
//   out_data     out  WIDTH                head entry (to register d)
//   out_valid    out  1                    FIFO non-empty
//   out_ready    in   1                    consumer takes head this cycle
//   count        out  $clog2(DEPTH+1)      current occupancy
//   almost_full  out  1                    count >= AFULL_LVL
// BEHAVIOUR
//   Interface: one clock (clk); reset is asynchronous and active-high (rst).
//   - Reset: rd/wr pointers = 0, storage = 0, count = 0.
//     Reset values: out_valid=0, out_data=0, in_ready=1, almost_full=0.
//   - Pointers are $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
//     empty = ptrs equal; full = index bits equal and wrap bits differ.
//     Index wrap DEPTH-1 -> 0 toggles the wrap bit.
//   - push = in_valid & in_ready; pop = out_valid & out_ready.
//   - in_ready = !full (combinational from registered state only; never
//     from out_ready). When full, a same-cycle pop does NOT permit a push.
//   - out_valid = !empty; out_data = mem[rd_idx] (registered storage).
//     There is no empty bypass.
//   - Latency: a byte pushed at edge N appears on out_data/out_valid after
//     edge N.
//   - push only: write mem[wr_idx], wr_ptr++, count++.
//     pop only: rd_ptr++, count--.
//     push & pop: both pointers advance, count unchanged.
//   - flush=1 at an edge: pointers and count = 0. The push/pop that cycle
//     is discarded. Storage contents are don't-care; out_data is
//     don't-care while out_valid=0.
//   - Async rst mid-operation: state clears immediately. Any in-flight
//     push is lost. Outputs show reset values while rst=1.
//   - in_valid with in_ready=0: no state change. Upstream must hold
//     in_data/in_valid stable until accepted.
//   - count never exceeds DEPTH and never underflows.
//   - almost_full is combinational from count.
// TESTING
//   1 Reset: pulse rst with in_valid=1, in_data=8'hAA -> out_valid=0,
//     count=0, in_ready=1; nothing is stored.
//   2 Fill: push 8'h11,22,33,44 with out_ready=0 -> count=4, in_ready=0,
//     almost_full=1 from count 3; out_data=8'h11.
//     A 5th push (8'h55) is held off.
//   3 Drain with wrap: from test 2, push 8'h55..58 while popping each
//     cycle -> order 11,22,33,44,55,56,57,58; no loss or duplicates.
//   4 Full + pop + push same cycle: FIFO full, out_ready=1, in_valid=1 ->
//     only the pop occurs, count=3. The next cycle the push is accepted.
//   5 Simultaneous push/pop at count=1 -> count stays 1; out_data goes to
//     the new byte the following cycle.
//   6 Flush with push and pop active, count=2 -> next cycle count=0,
//     out_valid=0; a later push of 8'h5A reads back 8'h5A.

Source files
------------

// File: rtl/byte_fifo.sv
// byte_fifo: first-word fall-through valid/ready FIFO with occupancy count
// and almost-full flag; feeds the d input of the downstream register stage.
module byte_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [AW:0]      wr_ptr_nxt_s;
  logic [AW:0]      rd_ptr_nxt_s;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt_s;
  logic             empty_s;
  logic             full_s;
  logic             push_s;
  logic             pop_s;

  // MSB of each pointer is the wrap bit; equal index with differing wrap means full
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) &&
                   (wr_ptr_r[AW] != rd_ptr_r[AW]);
  assign push_s  = in_valid & ~full_s;
  assign pop_s   = out_ready & ~empty_s;

  assign in_ready    = ~full_s;
  assign out_valid   = ~empty_s;
  assign out_data    = mem_r[rd_ptr_r[AW-1:0]];
  assign count       = count_r;
  assign almost_full = (count_r >= CW'(AFULL_LVL));

  // Next-state for pointers and occupancy; flush discards that cycle's push/pop
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    if (flush) begin
      wr_ptr_nxt_s = '0;
      rd_ptr_nxt_s = '0;
      count_nxt_s  = '0;
    end else begin
      if (push_s) begin
        wr_ptr_nxt_s = wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_nxt_s = count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
    end
  end

  // Storage array; written only on an accepted, non-flushed push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_s && !flush) begin
      mem_r[wr_ptr_r[AW-1:0]] <= in_data;
    end
  end

endmodule

// File: tb/tb_byte_fifo.sv
// tb_byte_fifo: directed scenarios plus randomized traffic against a
// queue-based reference model of the byte FIFO.
module tb_byte_fifo;

  localparam int DEPTH = 4;
  localparam int AFULL = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] count;
  logic       almost_full;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] mq[$];

  byte_fifo #(.WIDTH(8), .DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  // Advance one clock and update the reference queue from the pre-edge inputs
  task automatic step();
    bit pu, po;
    pu = in_valid && (mq.size() < DEPTH);
    po = out_ready && (mq.size() > 0);
    @(posedge clk);
    if (flush) mq.delete();
    else begin
      if (po) void'(mq.pop_front());
      if (pu) mq.push_back(in_data);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1 ||
        out_data !== 8'h00 || almost_full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_vals got v=%b c=%0d r=%b d=%h af=%b exp v=0 c=0 r=1 d=00 af=0",
               out_valid, count, in_ready, out_data, almost_full);
    end
    in_valid = 1'b0; rst = 1'b0; mq.delete();
    step();
    n_checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_nothing_stored got c=%0d v=%b exp c=0 v=0", count, out_valid);
    end
  endtask

  task automatic test_fill();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = vals[i];
      step();
      n_checks++;
      if (count !== 3'(i + 1) || almost_full !== ((i + 1) >= AFULL)) begin
        n_fail++;
        $display("FAIL fill_count[%0d] got c=%0d af=%b exp c=%0d af=%b",
                 i, count, almost_full, i + 1, (i + 1) >= AFULL);
      end
    end
    n_checks++;
    if (in_ready !== 1'b0 || out_data !== 8'h11) begin
      n_fail++;
      $display("FAIL fill_full got r=%b d=%h exp r=0 d=11", in_ready, out_data);
    end
    in_data = 8'h55;
    step();
    n_checks++;
    if (count !== 3'd4 || out_data !== 8'h11 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_hold5 got c=%0d d=%h r=%b exp c=4 d=11 r=0", count, out_data, in_ready);
    end
  endtask

  task automatic test_drain_wrap();
    logic [7:0] got[$];
    logic [7:0] nxt = 8'h55;
    logic [7:0] exp_b;
    bit acc;
    out_ready = 1'b1; in_valid = 1'b1; in_data = nxt;
    for (int cyc = 0; cyc < 40 && got.size() < 8; cyc++) begin
      if (out_valid) got.push_back(out_data);
      acc = in_valid && in_ready;
      step();
      if (acc) begin
        nxt = nxt + 8'h01;
        if (nxt > 8'h58) in_valid = 1'b0;
        in_data = nxt;
      end
      n_checks++;
      if (count !== 3'(mq.size())) begin
        n_fail++;
        $display("FAIL drain_count got %0d exp %0d", count, mq.size());
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (got.size() != 8) begin
      n_fail++;
      $display("FAIL drain_len got %0d exp 8", got.size());
    end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      exp_b = (i < 4) ? 8'(8'h11 * (i + 1)) : 8'(8'h55 + i - 4);
      n_checks++;
      if (got[i] !== exp_b) begin
        n_fail++;
        $display("FAIL drain_order[%0d] got %h exp %h", i, got[i], exp_b);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_full_pop_push();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'hC0 + 8'(i);
      step();
    end
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h99;
    step();
    n_checks++;
    if (count !== 3'd3 || out_data !== 8'hC1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL fullpp_pop_only got c=%0d d=%h r=%b exp c=3 d=c1 r=1", count, out_data, in_ready);
    end
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fullpp_push_next got c=%0d r=%b exp c=4 r=0", count, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_data !== mq[0] || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL fullpp_drain[%0d] got %h exp %h", i, out_data, mq[0]);
      end
      step();
    end
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL fullpp_empty got v=%b c=%0d exp v=0 c=0", out_valid, count);
    end
  endtask

  task automatic test_simul_count1();
    in_valid = 1'b1; in_data = 8'hA1; out_ready = 1'b0;
    step();
    in_data = 8'hB2; out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (count !== 3'd1 || out_data !== 8'hB2 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_c1 got c=%0d d=%h v=%b exp c=1 d=b2 v=1", count, out_data, out_valid);
    end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_data = 8'h0E; out_ready = 1'b0;
    step();
    n_checks++;
    if (count !== 3'd2) begin
      n_fail++;
      $display("FAIL flush_pre got %0d exp 2", count);
    end
    flush = 1'b1; in_data = 8'h77; out_ready = 1'b1;
    step();
    flush = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_clear got c=%0d v=%b r=%b exp c=0 v=0 r=1", count, out_valid, in_ready);
    end
    in_data = 8'h5A;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h5A || count !== 3'd1) begin
      n_fail++;
      $display("FAIL flush_readback got v=%b d=%h c=%0d exp v=1 d=5a c=1", out_valid, out_data, count);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!(in_valid && !in_ready)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      step();
      n_checks++;
      if (count !== 3'(mq.size()) || out_valid !== (mq.size() > 0) ||
          in_ready !== (mq.size() < DEPTH) || almost_full !== (mq.size() >= AFULL) ||
          (mq.size() > 0 && out_data !== mq[0])) begin
        n_fail++;
        $display("FAIL random[%0d] got c=%0d v=%b r=%b af=%b d=%h exp c=%0d head=%h",
                 cyc, count, out_valid, in_ready, almost_full, out_data,
                 mq.size(), (mq.size() > 0) ? mq[0] : 8'h00);
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h3C;
    step();
    in_data = 8'h3D;
    #2 rst = 1'b1;
    #1;
    mq.delete();
    n_checks++;
    if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1 || almost_full !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst got v=%b c=%0d r=%b af=%b exp v=0 c=0 r=1 af=0",
               out_valid, count, in_ready, almost_full);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b0;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL async_rst_lost got v=%b c=%0d exp v=0 c=0", out_valid, count);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain_wrap();
    test_full_pop_push();
    test_simul_count1();
    test_flush();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
